// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multicycle MIPS controller.
// Latency: n/a (declarations plus one pure decode function).
// Backpressure: n/a.
package mc_pkg;

  // Controller states; the numeric values are visible on the state register
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_TRAP    = 4'd12,
    S_BNEEX   = 4'd13
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Internal ALU op class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operation codes
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PC source selects
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Per-state datapath controls, held in the output register
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  // States that access memory and therefore stretch by the wait count
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  // Moore decode; 'last' marks the final wait cycle of the state
  function automatic ctrl_t ctrl_decode(state_t s, logic last);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALUOP_ADD;
        c.pcsrc   = PC_ALU;
        c.irwrite = last;
        c.pcwrite = last;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_BRANCH;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_BEQEX, S_BNEEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PC_ALUOUT;
        c.branch  = 1'b1;
      end
      S_JEX: begin
        c.pcsrc   = PC_JUMP;
        c.pcwrite = 1'b1;
      end
      S_TRAP: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// aludec: maps the controller's ALU op class and the R-type funct field to an ALU operation.
// Latency: combinational, zero cycles.
// Backpressure: none.
module aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  // Fixed add/sub for address and branch math, funct lookup for R-type
  always_comb begin
    alucontrol_o = ALUC_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUC_ADD;
      ALUOP_SUB: alucontrol_o = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALUC_ADD;
          FN_SUB:  alucontrol_o = ALUC_SUB;
          FN_AND:  alucontrol_o = ALUC_AND;
          FN_OR:   alucontrol_o = ALUC_OR;
          FN_SLT:  alucontrol_o = ALUC_SLT;
          default: alucontrol_o = ALUC_ADD;
        endcase
      end
      default: alucontrol_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM, wait-state counter and PC enable; MC_BNE_EN adds bne.
// Latency: state and controls registered; pcen and alucontrol add only zero/funct combinationally.
// Backpressure: memory states stretch by MEM_LAT wait cycles; illegal opcodes park in TRAP until reset.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       illegal_op
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, ctrl_act;
  logic   wait_done;   // current memory state is on its final cycle
  logic   last_d;      // next cycle is the final cycle of its state
  logic   bne_state;

  // Wait-state counter, present only when memory needs extra cycles
  generate
    if (MEM_LAT == 0) begin : g_no_wait
      assign wait_done = 1'b1;
      assign last_d    = 1'b1;
    end else begin : g_wait
      localparam int CW = $clog2(MEM_LAT + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      // Advance while a memory state is still waiting; any state change restarts at 0
      always_comb begin
        cnt_d = '0;
        if (reset_n && is_mem_state(state_q) && !wait_done) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      assign wait_done = (cnt_q == CW'(MEM_LAT));
      assign last_d    = (cnt_d == CW'(MEM_LAT));

      // Wait counter register
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // Next-state selection; op is only consulted in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    if (!reset_n) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: if (wait_done) state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_RTYPE:     state_d = S_RTYPEEX;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BEQEX;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
            OP_BNE:       state_d = S_BNEEX;
`else
            OP_BNE:       state_d = S_TRAP;
`endif
            default:      state_d = S_TRAP;
          endcase
        end
        S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (wait_done) state_d = S_MEMWB;
        S_MEMWR:   if (wait_done) state_d = S_FETCH;
        S_RTYPEEX: state_d = S_ALUWB;
        S_ADDIEX:  state_d = S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQEX, S_BNEEX, S_JEX: state_d = S_FETCH;
        S_TRAP:    state_d = S_TRAP;
        default:   state_d = S_TRAP;
      endcase
    end
  end

  // Controls for the upcoming state, so the output register lines up with the state register
  always_comb begin
    ctrl_d = ctrl_decode(state_d, last_d);
  end

  // State register and registered Moore outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_decode(S_FETCH, last_d);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Reset low silences every control immediately, so no write fires in a reset cycle
  always_comb begin
    ctrl_act = reset_n ? ctrl_q : '0;
  end

`ifdef MC_BNE_EN
  assign bne_state = (state_q == S_BNEEX);
`else
  assign bne_state = 1'b0;
`endif

  assign pcen = ctrl_act.pcwrite | (ctrl_act.branch & (zero ^ bne_state));

  aludec u_aludec (
    .aluop_i      (ctrl_act.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

  assign iord       = ctrl_act.iord;
  assign irwrite    = ctrl_act.irwrite;
  assign memwrite   = ctrl_act.memwrite;
  assign memtoreg   = ctrl_act.memtoreg;
  assign regwrite   = ctrl_act.regwrite;
  assign regdst     = ctrl_act.regdst;
  assign alusrca    = ctrl_act.alusrca;
  assign alusrcb    = ctrl_act.alusrcb;
  assign pcsrc      = ctrl_act.pcsrc;
  assign illegal_op = ctrl_act.illegal;

endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle MIPS control unit: a registered Moore state machine plus the ALU decoder and PC-enable logic. It sits beside the multicycle datapath and drives every mux select and write enable. It adds four things: a complete instruction set (lw, sw, R-type, beq, addi, j), a synchronous reset, configurable memory wait states, and a sticky trap on illegal opcodes.

## Interface
- MEM_LAT, default 0: extra wait cycles spent in each memory-access state (FETCH, MEMRD, MEMWR); range 0–7.
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- op  in  6  instruction opcode, bits [31:26] from the instruction register.
- funct  in  6  R-type function field, bits [5:0].
- zero  in  1  ALU zero flag.
- iord, irwrite, memwrite, memtoreg, regwrite, regdst, alusrca  out  1 each  datapath controls.
- alusrcb  out  2  ALU B-operand select.
- pcsrc  out  2  PC source select.
- alucontrol  out  3  ALU operation.
- pcen  out  1  PC register enable.
- illegal_op  out  1  sticky trap flag.

## Operation
- State register is 4 bits.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, TRAP 12, BNEEX 13.
- Transitions:
  - FETCH → DECODE.
  - DECODE → by op: 000000 RTYPEEX; 100011 or 101011 MEMADR; 000100 BEQEX; 001000 ADDIEX; 000010 JEX; anything else TRAP.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB.
  - RTYPEEX → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BEQEX, BNEEX, JEX → FETCH.
  - TRAP → TRAP, until reset.
- Outputs are a function of state only; any signal not listed for a state is 0.
  - FETCH: alusrcb=01, aluop=00, pcsrc=00; irwrite and pcwrite asserted on the final wait cycle only.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWR: iord=1, memwrite=1 on every cycle of the state.
  - MEMWB: memtoreg=1, regwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BEQEX and BNEEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - JEX: pcsrc=10, pcwrite=1.
  - TRAP: illegal_op=1.
- pcen = pcwrite | (branch & (zero ^ bne_state)).
- aluop is internal. ALU decode:
  - aluop 00 → 010 (add); 01 → 110 (sub).
  - aluop 10, by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, anything else → 010.
- Wait counter: width $clog2(MEM_LAT+1).
  - Cleared on entry to any memory state; increments while below MEM_LAT; the state exits when the counter equals MEM_LAT.
  - With MEM_LAT=0 the counter logic is absent and each memory state lasts 1 cycle.

## Timing
- reset_n is sampled on the clk rising edge. While reset_n=0 the state and wait counter load FETCH and 0.
- Every output is forced to 0 during reset, including irwrite, pcwrite, pcen and illegal_op; alusrcb reads 00 and alucontrol reads 010.
- The first cycle after reset_n rises is FETCH, wait count 0.
- Cycles per instruction, with L = MEM_LAT: lw 5+2L, sw 4+2L, R-type 4+L, addi 4+L, beq/bne 3+L, j 3+L.
- A state change takes effect on the edge following the final cycle of the current state; no combinational path from op to outputs.
- op and funct must be stable from DECODE through the end of the instruction; irwrite is only high on FETCH's last cycle.
- Reset mid-instruction aborts it. No write enable is asserted in the reset cycle, and the instruction is refetched afterwards.
- TRAP is only left through reset. In TRAP, pcen and all memory and register write enables stay 0.

## Configuration
- MC_BNE_EN defined:
  - op 000101 in DECODE → BNEEX.
  - bne_state=1 in BNEEX, so pcen = branch & ~zero.
- MC_BNE_EN undefined:
  - BNEEX encoding is unused and unreachable.
  - op 000101 → TRAP.
  - bne_state is tied to 0.

## Structure
- Package mc_pkg holds:
  - the state enum typedef with the encodings above;
  - opcode and funct localparams;
  - aluop and alucontrol constants.
- One sub-module, aludec: combinational, aluop + funct → alucontrol.
- The FSM, wait counter and pcen logic live in mc_controller.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with op=100011 → all outputs 0 throughout; the first cycle after release shows alusrcb=01, irwrite=1, pcen=1 (MEM_LAT=0).
- lw with MEM_LAT=0, op=100011 → states 0,1,2,3,4 then back to 0; regwrite=1 and memtoreg=1 in cycle 5 only.
- sw with MEM_LAT=2:
  - FETCH lasts 3 cycles, irwrite=1 in the 3rd only;
  - MEMWR lasts 3 cycles with memwrite=1 on all three;
  - 8 cycles in total.
- R-type op=000000, funct=101010 → alucontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in ALUWB.
- beq op=000100 with zero=1 → pcen=1, pcsrc=01; with zero=0 → pcen=0.
- Illegal op and bne:
  - op=111111 → TRAP with illegal_op=1, held for 10 cycles; cleared by reset.
  - With MC_BNE_EN, op=000101 and zero=0 → pcen=1.
